hub75_rx: RTL
=============

Name: hub75_rx

Overview:
- Panel-side receiver for the HUB75-style interface produced by the team's LED matrix driver.
- Oversamples the driver outputs (led_clk, r1..b2, a..d, lat) in the system clock domain and rebuilds each shifted row in a shift register.
- On each latch pulse, transfers the row and replays it as a stream of pixel-pair writes toward a framebuffer or checker.
- Used for loopback self-test and as the bench monitor for the driver.

Parameters:
COLS, 32, pixels per shifted row (shift-register depth)
ROW_BITS, 4, width of row address {a,b,c,d}; panel half-height = 2**ROW_BITS
SAMPLE_EDGE, 0, 0 = capture data on led_clk rising edge, 1 = on falling edge
SYNC_STAGES, 2, synchronizer depth applied identically to every panel input

Ports:
clk  in  1  system clock (≥ 4x led_clk frequency)
reset  in  1  asynchronous, active-high
led_clk_in  in  1  panel shift clock from driver
rgb_top  in  3  {r1,g1,b1}
rgb_bot  in  3  {r2,g2,b2}
row_addr_in  in  ROW_BITS  {a,b,c,d}, a = MSB
lat_in  in  1  latch strobe
pix_valid  out  1  pixel-pair beat valid
pix_ready  in  1  downstream accepts beat
pix_row  out  ROW_BITS  top-half row index; bottom-half row = pix_row + 2**ROW_BITS
pix_col  out  $clog2(COLS)  column index
pix_top  out  3  top-half rgb
pix_bot  out  3  bottom-half rgb
row_done  out  1  one-cycle pulse after last beat of a row
frame_done  out  1  one-cycle pulse coincident with row_done when drained row = 2**ROW_BITS-1
col_err  out  1  sticky: latch seen with shift count ≠ COLS
overrun  out  1  sticky: latch seen while previous row still draining

Behaviour:
- Reset (async): all outputs 0, shift count 0, FSM IDLE, synchronizer flops 0.
- Synchronization: all inputs pass through SYNC_STAGES flops. Data and address are delayed one extra flop so they are sampled mid-bit relative to the detected edge. The edge detector compares the last two synchronized led_clk/lat samples.
- Shift: on the selected led_clk edge, {rgb_top,rgb_bot} shifts in and shift count increments, saturating at 2*COLS-1. After COLS shifts, the first-shifted datum is column COLS-1 and the last-shifted datum is column 0, matching panel chain order.
- Latch (lat rising edge):
  - If FSM is IDLE: copy shift register to row buffer, capture row_addr_in, set col_err if count ≠ COLS (the row is still transferred), clear count, enter DRAIN.
  - If FSM is in DRAIN: set overrun, discard the new row, clear count, continue the current drain unchanged.
- Simultaneous shift edge and lat edge in the same clk cycle: the shift is applied first, then the latch uses the updated register and count.
- FSM states:
  - IDLE: pix_valid = 0.
  - DRAIN: pix_valid = 1, pix_col starts at 0. Advance on pix_valid & pix_ready. pix_* hold stable while ready is low.
  - After the beat with pix_col = COLS-1 is accepted: row_done = 1 for one cycle (plus frame_done when row = max), go to IDLE.
- Minimum drain time is COLS cycles. Overrun occurs whenever the next lat arrives before the drain completes.
- Sticky flags clear only on reset.
- Reset mid-drain aborts the drain with no row_done and clears all state.

Decomposition:
- hub75_pkg:
  - constants COLS_DEF=32, ROW_BITS_DEF=4
  - typedef rgb3_t (logic [2:0])
  - struct pix_pair_t {rgb3_t top, bot}
  - enum rx_state_t {IDLE, DRAIN}
- Sub-module hub75_in_sync: synchronizer bank, extra data delay, and rise/fall edge detect for led_clk and lat. Outputs shift_stb, lat_stb, data, and address in the clk domain.

Test Plan:
1. Reset, then 32 shifts of (top=3'b100, bot=3'b010), row_addr=4'b0101, lat → 32 beats with pix_row=5, cols 0..31, all pix_top=4, pix_bot=2; row_done once; col_err=0.
2. Shift data k=0..31 with top=k[2:0], then lat, pix_ready always 1 → beat col c carries top=(31-c)[2:0]; beats on 32 consecutive cycles.
3. Drive 16 rows, addresses 0..15, each with 32 shifts + lat → frame_done pulses exactly once, on row 15's row_done.
4. Only 31 shifts then lat → col_err=1, row still drained as 32 beats; the next correct row leaves col_err=1.
5. Hold pix_ready=0 for 100 cycles mid-row while the driver shifts and latches the next row → overrun=1, beats held stable, first row completes intact, second row dropped.
6. Assert reset at beat 10 of a drain → pix_valid=0 immediately, no row_done; the next full row drains normally from col 0.

Source files
------------

// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types and defaults for the HUB75 panel-side receiver
package hub75_pkg;
  localparam int COLS_DEF     = 32;
  localparam int ROW_BITS_DEF = 4;

  typedef logic [2:0] rgb3_t;

  typedef struct packed {
    rgb3_t top;
    rgb3_t bot;
  } pix_pair_t;

  typedef enum logic {IDLE, DRAIN} rx_state_t;
endpackage

// File: rtl/hub75_rx_if.sv
// rtl/hub75_rx_if.sv - pixel-pair beat stream from the receiver toward a framebuffer or checker
interface hub75_rx_if
  import hub75_pkg::*;
#(
  parameter int COLS     = COLS_DEF,
  parameter int ROW_BITS = ROW_BITS_DEF
);
  localparam int CW = $clog2(COLS);

  logic                pix_valid;
  logic                pix_ready;
  logic [ROW_BITS-1:0] pix_row;
  logic [CW-1:0]       pix_col;
  rgb3_t               pix_top;
  rgb3_t               pix_bot;

  modport master (output pix_valid, pix_row, pix_col, pix_top, pix_bot, input pix_ready);
  modport slave  (input pix_valid, pix_row, pix_col, pix_top, pix_bot, output pix_ready);
endinterface

// File: rtl/hub75_in_sync.sv
// rtl/hub75_in_sync.sv - synchronizer bank, one-flop data delay and led_clk/lat edge detect
module hub75_in_sync
  import hub75_pkg::*;
#(
  parameter int ROW_BITS    = ROW_BITS_DEF,
  parameter int SAMPLE_EDGE = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_led_clk,
  input  logic                i_lat,
  input  rgb3_t               i_rgb_top,
  input  rgb3_t               i_rgb_bot,
  input  logic [ROW_BITS-1:0] i_row_addr,
  output logic                o_shift_stb,
  output logic                o_lat_stb,
  output pix_pair_t           o_data,
  output logic [ROW_BITS-1:0] o_row_addr
);
  localparam int W = 8 + ROW_BITS;

  logic [W-1:0] r_sync [SYNC_STAGES];
  logic [W-1:0] r_dly;
  logic [W-1:0] w_in;
  logic         w_clk_cur;
  logic         w_clk_prev;
  logic         w_lat_cur;
  logic         w_lat_prev;

  assign w_in = {i_led_clk, i_lat, i_rgb_top, i_rgb_bot, i_row_addr};

  // Every input gets the same chain; the extra flop doubles as the edge-detect history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_dly <= '0;
    end else begin
      r_sync[0] <= w_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_dly <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_clk_cur  = r_sync[SYNC_STAGES-1][W-1];
  assign w_lat_cur  = r_sync[SYNC_STAGES-1][W-2];
  assign w_clk_prev = r_dly[W-1];
  assign w_lat_prev = r_dly[W-2];

  assign o_shift_stb = (SAMPLE_EDGE != 0) ? (~w_clk_cur & w_clk_prev) : (w_clk_cur & ~w_clk_prev);
  assign o_lat_stb   = w_lat_cur & ~w_lat_prev;
  assign o_data      = r_dly[W-3:ROW_BITS];
  assign o_row_addr  = r_dly[ROW_BITS-1:0];
endmodule

// File: rtl/hub75_rx.sv
// rtl/hub75_rx.sv - HUB75 panel-side receiver: rebuilds shifted rows and replays them as pixel-pair beats
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int COLS        = COLS_DEF,
  parameter int ROW_BITS    = ROW_BITS_DEF,
  parameter int SAMPLE_EDGE = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_led_clk_in,
  input  rgb3_t               i_rgb_top,
  input  rgb3_t               i_rgb_bot,
  input  logic [ROW_BITS-1:0] i_row_addr_in,
  input  logic                i_lat_in,
  hub75_rx_if.master          pix,
  output logic                o_row_done,
  output logic                o_frame_done,
  output logic                o_col_err,
  output logic                o_overrun
);
  localparam int CW = $clog2(COLS);
  localparam int NW = $clog2(2 * COLS);

  logic                w_shift_stb;
  logic                w_lat_stb;
  pix_pair_t           w_data;
  logic [ROW_BITS-1:0] w_addr;

  pix_pair_t           r_sr  [COLS];
  pix_pair_t           r_buf [COLS];
  pix_pair_t           w_sr_next [COLS];
  logic [NW-1:0]       r_cnt;
  logic [NW-1:0]       w_cnt_next;
  rx_state_t           r_state;
  logic                r_valid;
  logic [CW-1:0]       r_col;
  logic [ROW_BITS-1:0] r_row;

  hub75_in_sync #(
    .ROW_BITS   (ROW_BITS),
    .SAMPLE_EDGE(SAMPLE_EDGE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_led_clk  (i_led_clk_in),
    .i_lat      (i_lat_in),
    .i_rgb_top  (i_rgb_top),
    .i_rgb_bot  (i_rgb_bot),
    .i_row_addr (i_row_addr_in),
    .o_shift_stb(w_shift_stb),
    .o_lat_stb  (w_lat_stb),
    .o_data     (w_data),
    .o_row_addr (w_addr)
  );

  // Index 0 holds the last-shifted datum, so index == panel column
  always_comb begin
    w_sr_next  = r_sr;
    w_cnt_next = r_cnt;
    if (w_shift_stb) begin
      for (int j = COLS - 1; j > 0; j--) w_sr_next[j] = r_sr[j-1];
      w_sr_next[0] = w_data;
      if (r_cnt != NW'(2 * COLS - 1)) w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < COLS; j++) begin
        r_sr[j]  <= '0;
        r_buf[j] <= '0;
      end
      r_cnt        <= '0;
      r_state      <= IDLE;
      r_valid      <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      o_row_done   <= 1'b0;
      o_frame_done <= 1'b0;
      o_col_err    <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      r_sr         <= w_sr_next;
      r_cnt        <= w_lat_stb ? '0 : w_cnt_next;
      o_row_done   <= 1'b0;
      o_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_lat_stb) begin
            r_buf   <= w_sr_next;
            r_row   <= w_addr;
            r_col   <= '0;
            r_valid <= 1'b1;
            r_state <= DRAIN;
            if (w_cnt_next != NW'(COLS)) o_col_err <= 1'b1;
          end
        end
        DRAIN: begin
          // A latch here drops the incoming row; the current drain is untouched
          if (w_lat_stb) o_overrun <= 1'b1;
          if (pix.pix_ready) begin
            if (r_col == CW'(COLS - 1)) begin
              r_valid      <= 1'b0;
              r_state      <= IDLE;
              o_row_done   <= 1'b1;
              o_frame_done <= (r_row == '1);
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pix.pix_valid = r_valid;
  assign pix.pix_row   = r_row;
  assign pix.pix_col   = r_col;
  assign pix.pix_top   = r_buf[r_col].top;
  assign pix.pix_bot   = r_buf[r_col].bot;
endmodule
